btn_event: RTL and testbench
============================

# btn_event

Button event decoder for the register-file front panel. It consumes the clean, already-synchronous level produced by the button debouncer and turns it into single-cycle event strobes: press, release, click, long-press and auto-repeat. It sits between the debouncer and the register-file control FSM, so the control logic never handles raw button levels.

## Interface
- `LONG_CYCLES`, default 50_000_000 (500 ms at 100 MHz): cycles the button must be held after the press before `long_pulse` fires; must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000 (100 ms): auto-repeat period after a long press; must be ≥ 1.
- `REPEAT_EN`, default 1: 0 disables `repeat_pulse` entirely.
- `clk` input 1: single clock, 100 MHz.
- `rst` input 1: asynchronous, active-high reset.
- `btn_level` input 1: debounced button level, synchronous to `clk`, 1 = pressed.
- `press_pulse` output 1: one-cycle strobe on press.
- `release_pulse` output 1: one-cycle strobe on release.
- `click_pulse` output 1: one-cycle strobe on a release that happens before the long-press threshold.
- `long_pulse` output 1: one-cycle strobe when the long-press threshold is reached.
- `repeat_pulse` output 1: one-cycle strobe each repeat period while the button is long-held.
- `held` output 1: high while the button is in PRESSED or LONG.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also forces state IDLE, `btn_prev` to 0 and the counter to 0.
- `btn_prev` holds `btn_level` delayed by one cycle.
  - rise = `btn_level & ~btn_prev`
  - fall = `~btn_level & btn_prev`
- State machine:
  - **IDLE**: on rise, go to PRESSED, clear the counter and assert `press_pulse`.
  - **PRESSED**:
    - On fall, go to IDLE and assert `release_pulse` and `click_pulse`.
    - Otherwise, if counter == LONG_CYCLES−1, go to LONG, clear the counter and assert `long_pulse`.
    - Otherwise increment the counter.
  - **LONG**:
    - On fall, go to IDLE and assert `release_pulse` only.
    - Otherwise, if REPEAT_EN and counter == REPEAT_CYCLES−1, assert `repeat_pulse` and clear the counter.
    - Otherwise increment the counter.
- Counter width is `$clog2(max(LONG_CYCLES, REPEAT_CYCLES))`, unsigned. It never wraps: it is cleared at every terminal count or state change.
- Priority: fall beats the terminal count in the same cycle. The result is a click with no `long_pulse` and no `repeat_pulse`.
- The pulse outputs are mutually exclusive in any cycle, except `release_pulse` with `click_pulse`.
- A reset asserted mid-press goes to IDLE with no release or click strobe. If `btn_level` is still high after reset deasserts, `btn_prev` = 0 makes this a rise, so `press_pulse` fires.

## Timing
- Let edge N be the first clock edge that samples `btn_level` = 1 while `btn_prev` = 0.
  - `press_pulse` and `held` are high in the cycle following edge N.
- `long_pulse` is high in the cycle following edge N+LONG_CYCLES, i.e. exactly LONG_CYCLES cycles after `press_pulse`.
- `repeat_pulse` follows `long_pulse` by REPEAT_CYCLES cycles, then recurs every REPEAT_CYCLES cycles.
- Let edge M be the first edge that samples `btn_level` = 0.
  - `release_pulse` (and `click_pulse` if applicable) is high in the cycle following edge M.
  - `held` is low from that same cycle.
- Latency from the `btn_level` change to the output is 1 cycle. Every strobe is exactly 1 cycle wide.

## Structure
- Shared package `btn_pkg` holds:
  - state encodings `ST_IDLE` = 2'd0, `ST_PRESSED` = 2'd1, `ST_LONG` = 2'd2 (2'd3 is illegal and recovers to IDLE);
  - the default timing constants `CLK_HZ` = 100_000_000 and the ms-to-cycles conversion.
- No sub-module. The edge detector, counter and FSM stay in one module.
- The debouncer instance stays in the top level and feeds `btn_level`.

## Test plan
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=3, REPEAT_EN=1.

1. Reset with `btn_level` = 0 -> all outputs 0; hold 10 cycles -> still 0.
2. Raise `btn_level` for 4 cycles, then drop it -> `press_pulse` 1 cycle after the rise; `release_pulse` and `click_pulse` together 1 cycle after the fall; `held` high for exactly 4 cycles; no `long_pulse`.
3. Hold `btn_level` for 20 cycles ->
   - `press_pulse` at t+1;
   - `long_pulse` at t+9;
   - `repeat_pulse` at t+12, t+15, t+18;
   - `release_pulse` 1 cycle after the fall, with no `click_pulse`.
4. Drop `btn_level` so the fall is sampled on the same edge the counter hits 7 -> `click_pulse` and `release_pulse` assert, `long_pulse` never does.
5. Assert `rst` while in LONG with `btn_level` still high, then release it -> no `release_pulse`; `press_pulse` 1 cycle after the first post-reset edge.
6. With REPEAT_EN=0, hold for 20 cycles -> exactly one `long_pulse` at t+9 and zero `repeat_pulse`.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the front-panel button event logic: state encodings
// and default timing constants derived from the system clock.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_t;

  localparam int CLK_HZ = 100_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEFAULT_LONG_CYCLES   = ms_to_cycles(500);
  localparam int DEFAULT_REPEAT_CYCLES = ms_to_cycles(100);

endpackage

// File: rtl/btn_event.sv
// Turns the debounced button level into single-cycle press, release, click,
// long-press and auto-repeat strobes for the register-file control FSM.
module btn_event
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);

  btn_state_t    state;
  logic          btn_prev;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          fall;

  assign rise = btn_level & ~btn_prev;
  assign fall = ~btn_level & btn_prev;

  // A fall is checked before any terminal count so a release on the threshold
  // edge is still a click and never produces a long or repeat strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      btn_prev      <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      btn_prev      <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state       <= ST_PRESSED;
            cnt         <= '0;
            press_pulse <= 1'b1;
            held        <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (fall) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
            held          <= 1'b0;
          end else if (cnt == LONG_TC) begin
            state      <= ST_LONG;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LONG: begin
          if (fall) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (REPEAT_EN) begin
            // With repeat disabled the counter simply parks, so it cannot wrap.
            if (cnt == REPEAT_TC) begin
              cnt          <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event: directed scenarios plus a randomized run,
// compared every cycle against a hold-duration model of the button.
module tb_btn_event;

  localparam int L = 8;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;

  logic press_a, release_a, click_a, long_a, repeat_a, held_a;
  logic press_b, release_b, click_b, long_b, repeat_b, held_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: pressed flag, edges since the rise, last sample.
  bit m_press;
  int m_h;
  bit m_prev;

  int n_long_a, n_long_b, n_rep_a, n_rep_b, n_held, n_click, n_release, n_press;

  always #5 clk = ~clk;

  btn_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .press_pulse(press_a), .release_pulse(release_a), .click_pulse(click_a),
    .long_pulse(long_a), .repeat_pulse(repeat_a), .held(held_a)
  );

  btn_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .press_pulse(press_b), .release_pulse(release_b), .click_pulse(click_b),
    .long_pulse(long_b), .repeat_pulse(repeat_b), .held(held_b)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearCounts();
    n_long_a = 0; n_long_b = 0; n_rep_a = 0; n_rep_b = 0;
    n_held = 0; n_click = 0; n_release = 0; n_press = 0;
  endtask

  // Drive one level for one clock, advance the model, then compare both DUTs.
  task automatic applyStimulus(input bit lvl);
    bit e_press, e_rel, e_click, e_long, e_rep;
    btn_level = lvl;
    @(posedge clk);
    e_press = 0; e_rel = 0; e_click = 0; e_long = 0; e_rep = 0;
    if (rst) begin
      m_press = 0; m_h = 0; m_prev = 0;
    end else begin
      if (!m_press) begin
        if (lvl && !m_prev) begin
          m_press = 1; m_h = 0; e_press = 1;
        end
      end else begin
        m_h++;
        if (!lvl) begin
          e_rel   = 1;
          e_click = (m_h <= L);
          m_press = 0;
        end else begin
          e_long = (m_h == L);
          e_rep  = (m_h > L) && ((m_h - L) % R == 0);
        end
      end
      m_prev = lvl;
    end
    #1;
    checkOutput("press_a",   press_a,   e_press);
    checkOutput("release_a", release_a, e_rel);
    checkOutput("click_a",   click_a,   e_click);
    checkOutput("long_a",    long_a,    e_long);
    checkOutput("repeat_a",  repeat_a,  e_rep);
    checkOutput("held_a",    held_a,    m_press);
    checkOutput("press_b",   press_b,   e_press);
    checkOutput("release_b", release_b, e_rel);
    checkOutput("click_b",   click_b,   e_click);
    checkOutput("long_b",    long_b,    e_long);
    checkOutput("repeat_b",  repeat_b,  0);
    checkOutput("held_b",    held_b,    m_press);
    n_long_a  += int'(long_a);
    n_long_b  += int'(long_b);
    n_rep_a   += int'(repeat_a);
    n_rep_b   += int'(repeat_b);
    n_held    += int'(held_a);
    n_click   += int'(click_a);
    n_release += int'(release_a);
    n_press   += int'(press_a);
  endtask

  task automatic applyLevelFor(input bit lvl, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(lvl);
  endtask

  initial begin
    int run_len;
    bit lvl;
    m_press = 0; m_h = 0; m_prev = 0;
    clearCounts();

    // Scenario 1: reset state, then idle with button released.
    $display("[TB] reset and idle");
    #2;
    checkOutput("reset_held",  held_a,  0);
    checkOutput("reset_press", press_a, 0);
    applyLevelFor(0, 2);
    rst = 1'b0;
    applyLevelFor(0, 10);

    // Scenario 2: short press is a click.
    $display("[TB] short press");
    clearCounts();
    applyLevelFor(1, 4);
    applyLevelFor(0, 3);
    checkOutput("s2_held_cycles", n_held, 4);
    checkOutput("s2_clicks",      n_click, 1);
    checkOutput("s2_long",        n_long_a, 0);

    // Scenarios 3 and 6: long hold with repeats, and the repeat-disabled twin.
    $display("[TB] long hold");
    clearCounts();
    applyLevelFor(1, 20);
    applyLevelFor(0, 3);
    checkOutput("s3_long_a",  n_long_a, 1);
    checkOutput("s3_rep_a",   n_rep_a, 3);
    checkOutput("s6_long_b",  n_long_b, 1);
    checkOutput("s6_rep_b",   n_rep_b, 0);
    checkOutput("s3_click",   n_click, 0);
    checkOutput("s3_release", n_release, 1);

    // Scenario 4: fall sampled on the threshold edge.
    $display("[TB] release on threshold");
    clearCounts();
    applyLevelFor(1, L);
    applyLevelFor(0, 3);
    checkOutput("s4_click", n_click, 1);
    checkOutput("s4_long",  n_long_a, 0);

    // Scenario 5: reset while long-held, button still down afterwards.
    $display("[TB] reset during long press");
    clearCounts();
    applyLevelFor(1, L + 4);
    rst = 1'b1;
    #1;
    checkOutput("s5_held_in_reset", held_a, 0);
    applyLevelFor(1, 2);
    rst = 1'b0;
    applyLevelFor(1, 3);
    applyLevelFor(0, 2);
    checkOutput("s5_release", n_release, 1);
    checkOutput("s5_press",   n_press, 2);

    // Randomized run with occasional resets.
    $display("[TB] random run");
    lvl = 0;
    for (int k = 0; k < 60; k++) begin
      lvl = ~lvl;
      run_len = $urandom_range(1, 16);
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        applyStimulus(lvl);
        rst = 1'b0;
      end
      applyLevelFor(lvl, run_len);
    end
    applyLevelFor(0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
